jpeg_header_ctrl: RTL and testbench

- Sequencer for the JPEG header byte RAM (1024x8, registered read address, so data appears one cycle after the address).
- On `start`, patches the SOF0 height/width fields with the current frame size, then streams HDR_LEN header bytes to the output byte mux over a valid/ready interface.
- Sits between the host register block and the output byte mux, ahead of the entropy-coded scan data.

---
 rtl/jpeg_hdr_pkg.sv | 12 +
 rtl/jpeg_header_ctrl.sv | 131 +++++++++++++
 tb/tb_jpeg_header_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_hdr_pkg.sv
// jpeg_hdr_pkg: shared states and default layout constants for the JPEG header sequencer
package jpeg_hdr_pkg;
   typedef enum logic [1:0] {IDLE, PATCH, STREAM, DONE} hdr_state_t;
   localparam int HDR_ADDR_W       = 10;
   localparam int HDR_DATA_W       = 8;
   localparam int HDR_RAM_DEPTH    = 1 << HDR_ADDR_W;
   localparam int DEF_HDR_LEN      = 623;
   localparam int DEF_HEIGHT_OFS   = 163;
   localparam int DEF_WIDTH_OFS    = 165;
   localparam int DEF_LUMA_Q_OFS   = 25;
   localparam int DEF_CHROMA_Q_OFS = 94;
endpackage

// File: rtl/jpeg_header_ctrl.sv
// jpeg_header_ctrl: patches SOF0 frame size into the header RAM, then streams the header (QTAB_PATCH_EN adds host DQT writes)
module jpeg_header_ctrl
   import jpeg_hdr_pkg::*;
#(
   parameter int ADDR_W     = HDR_ADDR_W,
   parameter int HDR_LEN    = DEF_HDR_LEN,
   parameter int HEIGHT_OFS = DEF_HEIGHT_OFS,
   parameter int WIDTH_OFS  = DEF_WIDTH_OFS
`ifdef QTAB_PATCH_EN
   ,
   parameter int LUMA_Q_OFS   = DEF_LUMA_Q_OFS,
   parameter int CHROMA_Q_OFS = DEF_CHROMA_Q_OFS
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           img_width,
   input  logic [15:0]           img_height,
`ifdef QTAB_PATCH_EN
   input  logic                  qt_wr,
   input  logic [6:0]            qt_addr,
   input  logic [HDR_DATA_W-1:0] qt_data,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_waddr,
   output logic [HDR_DATA_W-1:0] ram_wdata,
   output logic [ADDR_W-1:0]     ram_raddr,
   input  logic [HDR_DATA_W-1:0] ram_q,
   output logic [HDR_DATA_W-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);
   hdr_state_t            r_state, w_state;
   logic [ADDR_W-1:0]     r_cnt, w_cnt, r_waddr, w_waddr;
   logic [1:0]            r_pc, w_pc;
   logic                  r_valid, w_valid, r_we, w_we;
   logic [HDR_DATA_W-1:0] r_wdata, w_wdata, r_h_lo, w_h_lo;
   logic [15:0]           r_w, w_w;
   logic                  w_acc, w_last;

   // Advancing the address only on a handshake keeps the RAM's registered address, and thus ram_q, frozen during a stall
   assign w_acc     = r_valid && out_ready;
   assign w_last    = w_acc && (r_cnt == ADDR_W'(HDR_LEN - 1));
   assign ram_raddr = w_acc ? r_cnt + ADDR_W'(1) : r_cnt;
   assign busy      = (r_state == PATCH) || (r_state == STREAM);
   assign done      = r_state == DONE;
   assign ram_we    = r_we;
   assign ram_waddr = r_waddr;
   assign ram_wdata = r_wdata;
   assign out_data  = ram_q;
   assign out_valid = r_valid;

   // Next state: sample frame size on start, issue the four SOF0 writes, then walk the read pointer
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_pc    = r_pc;
      w_valid = 1'b0;
      w_we    = 1'b0;
      w_waddr = r_waddr;
      w_wdata = r_wdata;
      w_h_lo  = r_h_lo;
      w_w     = r_w;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state = PATCH;
               w_h_lo  = img_height[7:0];
               w_w     = img_width;
               w_pc    = 2'd0;
               w_we    = 1'b1;
               w_waddr = ADDR_W'(HEIGHT_OFS);
               w_wdata = img_height[15:8];
            end
`ifdef QTAB_PATCH_EN
            else if (qt_wr) begin
               w_we    = 1'b1;
               w_waddr = qt_addr[6] ? ADDR_W'(CHROMA_Q_OFS) + ADDR_W'(qt_addr[5:0])
                                    : ADDR_W'(LUMA_Q_OFS) + ADDR_W'(qt_addr[5:0]);
               w_wdata = qt_data;
            end
`endif
         end
         PATCH: begin
            w_pc    = r_pc + 2'd1;
            w_we    = r_pc != 2'd3;
            w_waddr = (r_pc == 2'd0) ? ADDR_W'(HEIGHT_OFS + 1) : (r_pc == 2'd1) ? ADDR_W'(WIDTH_OFS) : ADDR_W'(WIDTH_OFS + 1);
            w_wdata = (r_pc == 2'd0) ? r_h_lo : (r_pc == 2'd1) ? r_w[15:8] : r_w[7:0];
            if (r_pc == 2'd3) begin
               w_state = STREAM;
               w_cnt   = '0;
            end
         end
         STREAM: begin
            w_cnt   = ram_raddr;
            w_valid = !w_last;
            if (w_last) w_state = DONE;
         end
         DONE: w_state = IDLE;
         default: w_state = IDLE;
      endcase
   end

   // State register with synchronous reset; reset aborts any header in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pc    <= 2'd0;
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_h_lo  <= '0;
         r_w     <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_pc    <= w_pc;
         r_valid <= w_valid;
         r_we    <= w_we;
         r_waddr <= w_waddr;
         r_wdata <= w_wdata;
         r_h_lo  <= w_h_lo;
         r_w     <= w_w;
      end
   end
endmodule

// File: tb/tb_jpeg_header_ctrl.sv
// tb_jpeg_header_ctrl: directed bench for jpeg_header_ctrl with a behavioural header RAM (QTAB_PATCH_EN enables the DQT test)
module tb_jpeg_header_ctrl;
   import jpeg_hdr_pkg::*;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic [15:0] img_width = '0, img_height = '0;
   logic busy, done, ram_we, out_valid;
   logic [9:0] ram_waddr, ram_raddr, r_raddr;
   logic [7:0] ram_wdata, ram_q, out_data;
   logic [7:0] mem [HDR_RAM_DEPTH];
   logic [7:0] exp_b [HDR_RAM_DEPTH];
`ifdef QTAB_PATCH_EN
   logic qt_wr = 1'b0;
   logic [6:0] qt_addr = '0;
   logic [7:0] qt_data = '0;
`endif
   int checks = 0, errors = 0, cyc = 0, t0 = 0;
   int stalls = 0, stall_err = 0, first_v = -1;
   logic p_stall = 1'b0;
   logic [7:0] p_data = '0;
   logic [9:0] wq_a [$];
   logic [7:0] wq_d [$];
   int wq_c [$];
   logic [7:0] bq [$];
   int dq [$];

   jpeg_header_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
`ifdef QTAB_PATCH_EN
      .qt_wr(qt_wr), .qt_addr(qt_addr), .qt_data(qt_data),
`endif
      .busy(busy), .done(done), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_raddr(ram_raddr), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      r_raddr <= ram_raddr;
   end
   assign ram_q = mem[r_raddr];

   always @(negedge clk) begin
      if (ram_we) begin
         wq_a.push_back(ram_waddr);
         wq_d.push_back(ram_wdata);
         wq_c.push_back(cyc);
      end
      if (out_valid && out_ready) bq.push_back(out_data);
      if (out_valid && !out_ready) stalls++;
      if (p_stall && out_valid && out_data !== p_data) stall_err++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) dq.push_back(cyc);
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
   end

   initial begin
      for (int i = 0; i < HDR_RAM_DEPTH; i++) begin
         mem[i]   = 8'(i * 37 + 11);
         exp_b[i] = 8'(i * 37 + 11);
      end
   end

   task automatic clear_mon();
      wq_a.delete(); wq_d.delete(); wq_c.delete(); bq.delete(); dq.delete();
      stalls = 0; stall_err = 0; first_v = -1;
   endtask

   task automatic do_start(input logic [15:0] w, input logic [15:0] h);
      @(posedge clk); #1;
      start = 1'b1; img_width = w; img_height = h; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (dq.size() == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (dq.size() == 0) begin
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles, required one", budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", ram_we); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      checks++; if ({ram_waddr, ram_wdata} !== 18'h0) begin errors++; $display("FAIL rst_wport: got %h/%h want 0/0", ram_waddr, ram_wdata); end
      checks++; if (ram_raddr !== 10'd0) begin errors++; $display("FAIL rst_raddr: got %0d want 0", ram_raddr); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] ed [4] = '{8'h02, 8'hD0, 8'h05, 8'h00};
      int bad = 0;
      clear_mon();
      out_ready = 1'b1;
      exp_b[163] = 8'h02; exp_b[164] = 8'hD0; exp_b[165] = 8'h05; exp_b[166] = 8'h00;
      do_start(16'd1280, 16'd720);
      wait_done(2000);
      repeat (5) @(negedge clk);
      checks++; if (wq_a.size() !== 4) begin errors++; $display("FAIL basic_nwr: got %0d writes want 4", wq_a.size()); end
      for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
         checks++;
         if (wq_a[i] !== 10'(163 + i) || wq_d[i] !== ed[i] || wq_c[i] - t0 !== i + 1) begin
            errors++;
            $display("FAIL basic_wr%0d: got addr %0d data %h cyc %0d want addr %0d data %h cyc %0d", i, wq_a[i], wq_d[i], wq_c[i] - t0, 163 + i, ed[i], i + 1);
         end
      end
      checks++; if (first_v - t0 !== 6) begin errors++; $display("FAIL basic_first_valid: got cycle %0d want 6", first_v - t0); end
      checks++; if (bq.size() !== 623) begin errors++; $display("FAIL basic_nbytes: got %0d want 623", bq.size()); end
      for (int i = 0; i < bq.size(); i++) if (bq[i] !== exp_b[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_bytes: got %0d wrong bytes want 0", bad); end
      checks++; if (dq.size() !== 1 || dq[0] - t0 !== 629) begin errors++; $display("FAIL basic_done: got %0d pulses first at %0d want 1 at 629", dq.size(), dq.size() ? dq[0] - t0 : -1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_random_ready();
      int n = 0, bad = 0;
      clear_mon();
      exp_b[163] = 8'h01; exp_b[164] = 8'hE0; exp_b[165] = 8'h02; exp_b[166] = 8'h80;
      do_start(16'd640, 16'd480);
      while (dq.size() == 0 && n < 5000) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      out_ready = 1'b1;
      wait_done(10);
      repeat (3) @(negedge clk);
      checks++; if (bq.size() !== 623) begin errors++; $display("FAIL rnd_nbytes: got %0d want 623", bq.size()); end
      for (int i = 0; i < bq.size(); i++) if (bq[i] !== exp_b[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_bytes: got %0d wrong bytes want 0", bad); end
      checks++; if (stall_err !== 0 || stalls == 0) begin errors++; $display("FAIL rnd_hold: got %0d changes in %0d stalls want 0 changes, >0 stalls", stall_err, stalls); end
      checks++; if (bq.size() > 163 && bq[163] !== 8'h01) begin errors++; $display("FAIL rnd_patched: got %h want 01", bq[163]); end
      checks++; if (dq.size() !== 1) begin errors++; $display("FAIL rnd_done: got %0d pulses want 1", dq.size()); end
   endtask

   task automatic test_back_to_back();
      int n = 0, bad = 0;
      clear_mon();
      out_ready = 1'b1;
      exp_b[163] = 8'h00; exp_b[164] = 8'hC8; exp_b[165] = 8'h00; exp_b[166] = 8'h64;
      do_start(16'd100, 16'd200);
      while (bq.size() < 50 && n < 200) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      start = 1'b1; img_width = 16'd999; img_height = 16'd999;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2000);
      repeat (20) @(negedge clk);
      checks++; if (wq_a.size() !== 4) begin errors++; $display("FAIL b2b_nwr: got %0d writes want 4", wq_a.size()); end
      checks++; if (bq.size() !== 623) begin errors++; $display("FAIL b2b_nbytes: got %0d want 623", bq.size()); end
      for (int i = 0; i < bq.size(); i++) if (bq[i] !== exp_b[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_bytes: got %0d wrong bytes want 0", bad); end
      checks++; if (dq.size() !== 1) begin errors++; $display("FAIL b2b_done: got %0d pulses want 1", dq.size()); end
   endtask

   task automatic test_reset_mid();
      int n = 0, bad = 0;
      clear_mon();
      out_ready = 1'b1;
      exp_b[163] = 8'h00; exp_b[164] = 8'hF0; exp_b[165] = 8'h01; exp_b[166] = 8'h40;
      do_start(16'd320, 16'd240);
      while (bq.size() < 100 && n < 300) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if ({out_valid, ram_we, busy, done} !== 4'b0) begin errors++; $display("FAIL rmid_outputs: got valid %b we %b busy %b done %b want all 0", out_valid, ram_we, busy, done); end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (dq.size() !== 0) begin errors++; $display("FAIL rmid_nodone: got %0d pulses want 0", dq.size()); end
      clear_mon();
      do_start(16'd320, 16'd240);
      wait_done(2000);
      checks++; if (first_v - t0 !== 6) begin errors++; $display("FAIL rmid_first_valid: got cycle %0d want 6", first_v - t0); end
      checks++; if (bq.size() !== 623) begin errors++; $display("FAIL rmid_nbytes: got %0d want 623", bq.size()); end
      for (int i = 0; i < bq.size(); i++) if (bq[i] !== exp_b[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_bytes: got %0d wrong bytes want 0", bad); end
   endtask

   task automatic test_last_stall();
      int n = 0;
      clear_mon();
      out_ready = 1'b1;
      exp_b[163] = 8'h04; exp_b[164] = 8'h38; exp_b[165] = 8'h07; exp_b[166] = 8'h80;
      do_start(16'd1920, 16'd1080);
      while (dq.size() == 0 && n < 2000) begin
         @(posedge clk); #1;
         out_ready = !(cyc >= t0 + 628 && cyc <= t0 + 632);
         n++;
      end
      out_ready = 1'b1;
      wait_done(10);
      checks++; if (stalls !== 5 || stall_err !== 0) begin errors++; $display("FAIL last_hold: got %0d stalls %0d changes want 5 stalls 0 changes", stalls, stall_err); end
      checks++; if (bq.size() !== 623 || bq[bq.size() - 1] !== exp_b[622]) begin errors++; $display("FAIL last_byte: got %0d bytes last %h want 623 last %h", bq.size(), bq.size() ? bq[bq.size() - 1] : 8'h0, exp_b[622]); end
      checks++; if (dq.size() !== 1 || dq[0] - t0 !== 634) begin errors++; $display("FAIL last_done: got %0d pulses at %0d want 1 at 634", dq.size(), dq.size() ? dq[0] - t0 : -1); end
   endtask

`ifdef QTAB_PATCH_EN
   task automatic test_qtab();
      int n = 0, bad = 0;
      clear_mon();
      out_ready = 1'b1;
      @(posedge clk); #1;
      qt_wr = 1'b1; qt_addr = 7'd64; qt_data = 8'h11;
      @(posedge clk); #1;
      qt_wr = 1'b0;
      @(negedge clk);
      checks++; if (wq_a.size() !== 1 || wq_a[0] !== 10'd94 || wq_d[0] !== 8'h11) begin errors++; $display("FAIL qt_idle: got %0d writes want 1 write of 11 at 94", wq_a.size()); end
      exp_b[94] = 8'h11;
      clear_mon();
      exp_b[163] = 8'h02; exp_b[164] = 8'hD0; exp_b[165] = 8'h05; exp_b[166] = 8'h00;
      do_start(16'd1280, 16'd720);
      while (bq.size() < 10 && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      qt_wr = 1'b1; qt_addr = 7'd3; qt_data = 8'h55;
      @(posedge clk); #1;
      qt_wr = 1'b0;
      wait_done(2000);
      checks++; if (wq_a.size() !== 4) begin errors++; $display("FAIL qt_busy: got %0d writes want 4", wq_a.size()); end
      for (int i = 0; i < bq.size(); i++) if (bq[i] !== exp_b[i]) bad++;
      checks++; if (bad !== 0 || bq.size() !== 623) begin errors++; $display("FAIL qt_bytes: got %0d wrong of %0d want 0 of 623", bad, bq.size()); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_random_ready();
      test_back_to_back();
      test_reset_mid();
      test_last_stall();
`ifdef QTAB_PATCH_EN
      test_qtab();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
